// File: rtl/lfsr_pkg.sv
// Shared constants and types for the LFSR word generator.
package lfsr_pkg;

  // Feedback network selection
  localparam int MODE_FIB    = 0;
  localparam int MODE_GALOIS = 1;

  // Maximal-length polynomials; bit i = coefficient of x^i, x^WIDTH implied
  localparam logic [3:0]  POLY_4  = 4'h3;
  localparam logic [7:0]  POLY_8  = 8'h1D;
  localparam logic [15:0] POLY_16 = 16'h6801;
  localparam logic [31:0] POLY_32 = 32'h000000C5;

  // Handshake controller states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } lfsr_st_e;

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR step: Fibonacci (shift in XOR of tapped bits) or
// Galois (shift out MSB and fold it back through the polynomial).
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'h6801,
  parameter int               MODE  = MODE_FIB
) (
  input  logic [WIDTH-1:0] i_s,
  output logic [WIDTH-1:0] o_next
);

  generate
    if (MODE == MODE_GALOIS) begin : g_galois
      // Galois: x * s mod P(x)
      assign o_next = {i_s[WIDTH-2:0], 1'b0} ^ ({WIDTH{i_s[WIDTH-1]}} & POLY);
    end else begin : g_fib
      // Fibonacci: the x^WIDTH term taps the MSB, POLY[0] is the implied output tap
      logic [WIDTH-1:0] w_mask;
      assign w_mask = {1'b1, POLY[WIDTH-1:1]};
      assign o_next = {i_s[WIDTH-2:0], ^(i_s & w_mask)};
    end
  endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// LFSR pseudo-random word source with valid/ready output, sanitised seed load
// and period tracking against the most recently loaded seed.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] POLY         = 16'h6801,
  parameter int               MODE         = MODE_FIB,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] q,
  output logic             bit_out,
  output logic             lockup,
  output logic             period_done,
  output logic [WIDTH-1:0] period_cnt
);

  lfsr_st_e         r_fsm;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_ref;
  logic [WIDTH-1:0] r_cnt;
  logic             r_valid;
  logic             r_lockup;
  logic             r_pdone;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_seed;
  logic             w_seed_zero;
  logic             w_accept;

  lfsr_next #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .MODE  (MODE)
  ) u_next (
    .i_s    (r_state),
    .o_next (w_next)
  );

  // A zero seed would lock the register at zero forever; substitute the default
  assign w_seed_zero = (seed == '0);
  assign w_seed      = w_seed_zero ? DEFAULT_SEED : seed;
  assign w_accept    = r_valid & out_ready;

  // Controller, state register, reference seed and period counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm    <= ST_IDLE;
      r_state  <= DEFAULT_SEED;
      r_ref    <= DEFAULT_SEED;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_lockup <= 1'b0;
      r_pdone  <= 1'b0;
    end else begin
      r_lockup <= 1'b0;
      r_pdone  <= 1'b0;
      if (ld) begin
        // Load overrides everything; a pending word is dropped
        r_state  <= w_seed;
        r_ref    <= w_seed;
        r_cnt    <= '0;
        r_fsm    <= ST_IDLE;
        r_valid  <= 1'b0;
        r_lockup <= w_seed_zero;
      end else begin
        case (r_fsm)
          ST_IDLE: begin
            if (en) begin
              r_fsm   <= ST_RUN;
              r_valid <= 1'b1;
            end
          end
          ST_RUN: begin
            // Without an accept the word is held even if en drops
            if (w_accept) begin
              r_state <= w_next;
              if (w_next == r_ref) begin
                r_cnt   <= '0;
                r_pdone <= 1'b1;
              end else begin
                r_cnt   <= r_cnt + 1'b1;
              end
              if (!en) begin
                r_fsm   <= ST_IDLE;
                r_valid <= 1'b0;
              end
            end
          end
          default: begin
            r_fsm   <= ST_IDLE;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_valid   = r_valid;
  assign q           = r_state;
  assign bit_out     = r_state[WIDTH-1];
  assign lockup      = r_lockup;
  assign period_done = r_pdone;
  assign period_cnt  = r_cnt;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: WIDTH=4 Fibonacci and Galois instances share stimulus and
// are compared every cycle against a polynomial-arithmetic reference model.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld, en, out_ready;
  logic [3:0] seed;

  logic       v_f, bo_f, lk_f, pd_f;
  logic [3:0] q_f, cnt_f;
  logic       v_g, bo_g, lk_g, pd_g;
  logic [3:0] q_g, cnt_g;

  int n_chk = 0;
  int n_err = 0;

  // Reference state per instance: [0] = Fibonacci, [1] = Galois
  logic [3:0] m_q[2], m_ref[2], m_cnt[2];
  logic       m_v[2], m_lk[2], m_pd[2];

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(4), .POLY(4'h3), .MODE(0), .DEFAULT_SEED(4'h1)) u_fib (
    .clk(clk), .reset(reset), .ld(ld), .seed(seed), .en(en), .out_ready(out_ready),
    .out_valid(v_f), .q(q_f), .bit_out(bo_f), .lockup(lk_f),
    .period_done(pd_f), .period_cnt(cnt_f)
  );

  lfsr_gen #(.WIDTH(4), .POLY(4'h3), .MODE(1), .DEFAULT_SEED(4'h1)) u_gal (
    .clk(clk), .reset(reset), .ld(ld), .seed(seed), .en(en), .out_ready(out_ready),
    .out_valid(v_g), .q(q_g), .bit_out(bo_g), .lockup(lk_g),
    .period_done(pd_g), .period_cnt(cnt_g)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference next word for P(x) = x^4 + x + 1
  function automatic logic [3:0] ref_next(input int m, input logic [3:0] s);
    int t;
    if (m == 1) begin
      // Galois: multiply by x, reduce modulo P(x) = 0x13
      t = int'(s) * 2;
      if (t >= 16) t = t ^ 'h13;
    end else begin
      // Fibonacci: new bit = s3 xor s0 (taps from x^4 and x^0 terms)
      t = ((int'(s) * 2) + (((int'(s) >> 3) ^ int'(s)) & 1)) & 15;
    end
    return t[3:0];
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_q[m] = 4'h1; m_ref[m] = 4'h1; m_cnt[m] = 4'h0;
      m_v[m] = 1'b0; m_lk[m] = 1'b0; m_pd[m] = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("f_valid", v_f,   m_v[0]);
    check("f_q",     q_f,   m_q[0]);
    check("f_bit",   bo_f,  m_q[0][3]);
    check("f_lock",  lk_f,  m_lk[0]);
    check("f_pdone", pd_f,  m_pd[0]);
    check("f_cnt",   cnt_f, m_cnt[0]);
    check("g_valid", v_g,   m_v[1]);
    check("g_q",     q_g,   m_q[1]);
    check("g_bit",   bo_g,  m_q[1][3]);
    check("g_lock",  lk_g,  m_lk[1]);
    check("g_pdone", pd_g,  m_pd[1]);
    check("g_cnt",   cnt_g, m_cnt[1]);
  endtask

  // Called at a negedge: drive inputs, advance model across the posedge, check
  task automatic step(input logic e, input logic r, input logic l, input logic [3:0] sd);
    logic [3:0] nx;
    en = e; out_ready = r; ld = l; seed = sd;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      m_lk[m] = 1'b0;
      m_pd[m] = 1'b0;
      if (l) begin
        m_q[m]   = (sd == 4'h0) ? 4'h1 : sd;
        m_ref[m] = m_q[m];
        m_cnt[m] = 4'h0;
        m_v[m]   = 1'b0;
        m_lk[m]  = (sd == 4'h0);
      end else if (m_v[m] && r) begin
        nx       = ref_next(m, m_q[m]);
        m_pd[m]  = (nx == m_ref[m]);
        m_cnt[m] = m_pd[m] ? 4'h0 : m_cnt[m] + 4'h1;
        m_q[m]   = nx;
        m_v[m]   = e;
      end else if (!m_v[m] && e) begin
        m_v[m] = 1'b1;
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [3:0] fib_exp[5];
    logic [3:0] gal_exp[6];
    logic [3:0] held;
    logic [3:0] sd;
    fib_exp = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE};
    gal_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6};

    reset = 1'b1; ld = 1'b0; en = 1'b0; out_ready = 1'b0; seed = 4'h0;
    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    // Free-running sequences in both modes; 15th accept wraps the period
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b1, 1'b0, 4'h0);
      if (k <= 5) check("fib_seq", q_f, fib_exp[k-1]);
      if (k <= 6) check("gal_seq", q_g, gal_exp[k-1]);
      if (k == 15) check("f_pd_early", pd_f, 1'b0);
    end
    check("f_wrap_pd",  pd_f,  1'b1);
    check("g_wrap_pd",  pd_g,  1'b1);
    check("f_wrap_cnt", cnt_f, 4'h0);
    check("f_wrap_q",   q_f,   4'h1);
    step(1'b1, 1'b1, 1'b0, 4'h0);
    check("f_pd_pulse", pd_f, 1'b0);

    // Backpressure: word and count frozen, then resume without a skip
    step(1'b1, 1'b1, 1'b0, 4'h0);
    held = q_f;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b0, 4'h0);
      check("bp_valid", v_f, 1'b1);
      check("bp_hold",  q_f, held);
    end
    step(1'b1, 1'b1, 1'b0, 4'h0);
    check("bp_resume", q_f, ref_next(0, held));

    // Zero-seed load with a word pending
    step(1'b1, 1'b0, 1'b1, 4'h0);
    check("ld0_lock",  lk_f, 1'b1);
    check("ld0_valid", v_f,  1'b0);
    check("ld0_q",     q_f,  4'h1);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    check("ld0_lock_pulse", lk_f, 1'b0);

    // Load collides with an accept: load wins
    step(1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b1, 4'h9);
    check("ldacc_q",  q_f,  4'h9);
    check("ldacc_v",  v_f,  1'b0);
    check("ldacc_pd", pd_f, 1'b0);

    // Asynchronous reset mid-sequence at q=0111
    step(1'b0, 1'b0, 1'b1, 4'h1);
    step(1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b0, 4'h0);
    check("pre_rst_q", q_f, 4'h7);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("rst_q",   q_f,   4'h1);
    check("rst_v",   v_f,   1'b0);
    check("rst_cnt", cnt_f, 4'h0);
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    // Randomised traffic against the model
    for (int k = 0; k < 600; k++) begin
      sd = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 29) == 0), sd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
